even_parity_rx: RTL and testbench

Serial receiver for the team's even-parity byte frame: samples one bit per enabled clock, deserializes a start bit, 8 data bits (LSB first), an even-parity bit and a stop bit, and presents the byte with parity and framing status. It is the receiving end of the parity-protected serial link. It sits behind the bit-rate strobe generator and feeds byte-wide consumers with a one-cycle valid pulse.

---
 rtl/even_parity_rx_pkg.sv | 15 +
 rtl/even_parity_rx_if.sv | 35 +++
 rtl/even_parity_rx.sv | 84 ++++++++
 tb/tb_even_parity_rx.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/even_parity_rx_pkg.sv
// Shared types for the even-parity serial link.
// Used by both the receiver and the matching transmitter.
package even_parity_rx_pkg;

    localparam int DEF_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DATA   = 3'd1,
        PARITY = 3'd2,
        STOP   = 3'd3,
        BREAK  = 3'd4
    } state_t;

endpackage

// File: rtl/even_parity_rx_if.sv
// Serial-in / byte-out bundle of the even-parity receiver.
// The master side drives the line and strobe; the slave side is the receiver.
interface even_parity_rx_if #(
    parameter int DATA_W = 8
);

    logic              bit_en;
    logic              rx_in;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              parity_err;
    logic              frame_err;
    logic              busy;

    modport master (
        output bit_en,
        output rx_in,
        input  data_out,
        input  data_valid,
        input  parity_err,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  bit_en,
        input  rx_in,
        output data_out,
        output data_valid,
        output parity_err,
        output frame_err,
        output busy
    );

endinterface

// File: rtl/even_parity_rx.sv
// Even-parity serial frame receiver: start, DATA_W bits LSB first,
// parity, stop. One sample per bit_en strobe.
module even_parity_rx
    import even_parity_rx_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic           clk,
    input  logic           rst_n,
    even_parity_rx_if.slave rx
);

    localparam int CW = $clog2(DATA_W) + 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    state_t            state;
    logic [CW-1:0]     cnt;
    logic              acc;
    logic [DATA_W-1:0] shreg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            acc           <= 1'b0;
            shreg         <= '0;
            rx.data_out   <= '0;
            rx.data_valid <= 1'b0;
            rx.parity_err <= 1'b0;
            rx.frame_err  <= 1'b0;
            rx.busy       <= 1'b0;
        end else begin
            rx.data_valid <= 1'b0;
            if (rx.bit_en) begin
                unique case (state)
                    IDLE: begin
                        if (!rx.rx_in) begin
                            state   <= DATA;
                            cnt     <= '0;
                            acc     <= 1'b0;
                            rx.busy <= 1'b1;
                        end
                    end
                    DATA: begin
                        for (int i = 0; i < DATA_W; i++) begin
                            if (cnt == CW'(i)) shreg[i] <= rx.rx_in;
                        end
                        acc <= acc ^ rx.rx_in;
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) state <= PARITY;
                    end
                    PARITY: begin
                        acc   <= acc ^ rx.rx_in;
                        state <= STOP;
                    end
                    STOP: begin
                        rx.data_out   <= shreg;
                        rx.parity_err <= acc;
                        rx.frame_err  <= ~rx.rx_in;
                        rx.data_valid <= 1'b1;
                        // A low stop bit parks in BREAK until the line idles
                        if (rx.rx_in) begin
                            state   <= IDLE;
                            rx.busy <= 1'b0;
                        end else begin
                            state   <= BREAK;
                        end
                    end
                    BREAK: begin
                        if (rx.rx_in) begin
                            state   <= IDLE;
                            rx.busy <= 1'b0;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        rx.busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_even_parity_rx.sv
// Directed table-driven bench for even_parity_rx.
// Includes break, strobe-divided, mid-frame reset and back-to-back cases.
module tb_even_parity_rx;

    logic clk;
    logic rst_n;

    even_parity_rx_if #(.DATA_W(8)) bus ();

    even_parity_rx #(.DATA_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       p;
        logic       stop;
        logic       exp_pe;
        logic       exp_fe;
    } vec_t;

    int checks;
    int errors;
    int cyc;
    int vcount;
    int vlast;
    int start_cyc;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic en, input logic b);
        @(negedge clk);
        bus.bit_en = en;
        bus.rx_in  = b;
        @(posedge clk);
        #1;
        cyc++;
        if (bus.data_valid) begin
            vcount++;
            vlast = cyc;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p,
                              input logic s, input int div);
        logic [10:0] bits;
        bits = {s, p, d, 1'b0};
        for (int b = 0; b < 11; b++) begin
            for (int k = 0; k < div; k++) begin
                step(k == div - 1, bits[b]);
                if (b == 0 && k == div - 1) start_cyc = cyc;
            end
        end
    endtask

    vec_t vecs[7];
    int   v0;
    int   lows;
    int   first_v;

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h07, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{8'h07, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'h80, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{8'h3C, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b1};

        checks = 0;
        errors = 0;
        cyc    = 0;
        vcount = 0;
        vlast  = 0;
        clk    = 1'b0;
        rst_n  = 1'b0;
        bus.bit_en = 1'b0;
        bus.rx_in  = 1'b1;

        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        chk("rst_data", 32'(bus.data_out), 0);
        chk("rst_valid", 32'(bus.data_valid), 0);
        chk("rst_pe", 32'(bus.parity_err), 0);
        chk("rst_fe", 32'(bus.frame_err), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        rst_n = 1'b1;
        step(1'b1, 1'b1);

        for (int i = 0; i < 7; i++) begin
            v0 = vcount;
            send_frame(vecs[i].data, vecs[i].p, vecs[i].stop, 1);
            chk($sformatf("v%0d_vcyc", i), 32'(vlast), 32'(start_cyc + 10));
            chk($sformatf("v%0d_data", i), 32'(bus.data_out), 32'(vecs[i].data));
            chk($sformatf("v%0d_pe", i), 32'(bus.parity_err), 32'(vecs[i].exp_pe));
            chk($sformatf("v%0d_fe", i), 32'(bus.frame_err), 32'(vecs[i].exp_fe));
            chk($sformatf("v%0d_busy", i), 32'(bus.busy), 32'(!vecs[i].stop));
            step(1'b1, 1'b1);
            chk($sformatf("v%0d_pulses", i), 32'(vcount - v0), 1);
            chk($sformatf("v%0d_idle", i), 32'(bus.busy), 0);
        end

        // Break: low stop then line held low
        v0 = vcount;
        send_frame(8'h3C, 1'b0, 1'b0, 1);
        lows = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0);
            if (!bus.busy) lows++;
        end
        chk("brk_fe", 32'(bus.frame_err), 1);
        chk("brk_pe", 32'(bus.parity_err), 0);
        chk("brk_data", 32'(bus.data_out), 32'h3C);
        chk("brk_pulses", 32'(vcount - v0), 1);
        chk("brk_busy_lows", 32'(lows), 0);
        step(1'b1, 1'b1);
        chk("brk_exit", 32'(bus.busy), 0);
        send_frame(8'h81, 1'b0, 1'b1, 1);
        chk("brk_next_data", 32'(bus.data_out), 32'h81);
        chk("brk_next_pe", 32'(bus.parity_err), 0);
        chk("brk_next_fe", 32'(bus.frame_err), 0);
        step(1'b1, 1'b1);

        // Strobe every 4th cycle
        v0 = vcount;
        send_frame(8'h5A, 1'b0, 1'b1, 4);
        chk("div4_vcyc", 32'(vlast), 32'(start_cyc + 40));
        chk("div4_data", 32'(bus.data_out), 32'h5A);
        chk("div4_pe", 32'(bus.parity_err), 0);
        chk("div4_fe", 32'(bus.frame_err), 0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        chk("div4_hold_data", 32'(bus.data_out), 32'h5A);
        chk("div4_hold_valid", 32'(bus.data_valid), 0);
        chk("div4_hold_busy", 32'(bus.busy), 0);
        chk("div4_pulses", 32'(vcount - v0), 1);
        step(1'b1, 1'b1);

        // Reset after 4 data bits
        v0 = vcount;
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        chk("mid_busy_pre", 32'(bus.busy), 1);
        rst_n = 1'b0;
        step(1'b1, 1'b1);
        rst_n = 1'b1;
        chk("mid_data", 32'(bus.data_out), 0);
        chk("mid_pe", 32'(bus.parity_err), 0);
        chk("mid_fe", 32'(bus.frame_err), 0);
        chk("mid_busy", 32'(bus.busy), 0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1);
        chk("mid_pulses", 32'(vcount - v0), 0);
        send_frame(8'hFF, 1'b0, 1'b1, 1);
        chk("mid_next_data", 32'(bus.data_out), 32'hFF);
        chk("mid_next_pe", 32'(bus.parity_err), 0);
        chk("mid_next_fe", 32'(bus.frame_err), 0);
        step(1'b1, 1'b1);

        // Back-to-back frames, no idle bit
        v0 = vcount;
        send_frame(8'h11, 1'b0, 1'b1, 1);
        first_v = vlast;
        chk("b2b_data0", 32'(bus.data_out), 32'h11);
        chk("b2b_pe0", 32'(bus.parity_err), 0);
        chk("b2b_fe0", 32'(bus.frame_err), 0);
        send_frame(8'hEE, 1'b0, 1'b1, 1);
        chk("b2b_data1", 32'(bus.data_out), 32'hEE);
        chk("b2b_pe1", 32'(bus.parity_err), 0);
        chk("b2b_fe1", 32'(bus.frame_err), 0);
        chk("b2b_gap", 32'(vlast - first_v), 11);
        step(1'b1, 1'b1);
        chk("b2b_pulses", 32'(vcount - v0), 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
